// File: rtl/spi_master_controller.sv
// SPI master for coprocessor slaves: mark/ack request, LSB-first packet out, response mark,
// fixed-width LSB-first result in. Sclk is the system clock, driven by the parent.
module spi_master_controller #(
  parameter int NumSlaves     = 3,
  parameter int MaxTxBits     = 40,
  parameter int RxBits        = 16,
  parameter int TimeoutCycles = 255,
  localparam int SlaveW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
  localparam int LenW   = $clog2(MaxTxBits + 1),
  localparam int CntW   = $clog2(((MaxTxBits > RxBits) ? MaxTxBits : RxBits) + 1),
  localparam int WaitW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [SlaveW-1:0]    i_slave,
  input  logic [LenW-1:0]      i_tx_len,
  input  logic [MaxTxBits-1:0] i_tx_data,
  input  logic                 i_abort,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_error,
  output logic [RxBits-1:0]    o_rx_data,
  output logic [NumSlaves-1:0] o_nss,
  output logic                 o_mosi,
  input  logic                 i_miso,
  output logic [2:0]           o_dbg_state
);

  // Request handshake: i_start is a strobe taken only while o_ready=1 (no backpressure
  // queue); completion is the single-cycle o_done pulse, o_error qualifying it.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_SHIFT_OUT = 3'd2,
    ST_AWAIT     = 3'd3,
    ST_SHIFT_IN  = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [SlaveW-1:0]    slave_q, slave_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [MaxTxBits-1:0] tx_q, tx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic [RxBits-1:0]    rx_shift_q, rx_shift_d;
  logic [RxBits-1:0]    rx_data_q, rx_data_d;
  logic                 err_q, err_d;

  logic                 illegal_req;
  logic                 active;
  logic                 wait_expired;
  logic [NumSlaves-1:0] nss_sel;

  assign illegal_req  = (int'(i_slave) >= NumSlaves) || (i_tx_len == '0) ||
                        (int'(i_tx_len) > MaxTxBits);
  assign active       = (state_q == ST_REQUEST) || (state_q == ST_SHIFT_OUT) ||
                        (state_q == ST_AWAIT) || (state_q == ST_SHIFT_IN);
  assign wait_expired = (wait_q == WaitW'(TimeoutCycles - 1));
  assign nss_sel      = ~(NumSlaves'(1) << slave_q);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      slave_q    <= '0;
      len_q      <= '0;
      tx_q       <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slave_q    <= slave_d;
      len_q      <= len_d;
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slave_d    = slave_q;
    len_d      = len_q;
    tx_d       = tx_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          slave_d = i_slave;
          len_d   = i_tx_len;
          tx_d    = i_tx_data;
          cnt_d   = '0;
          wait_d  = '0;
          err_d   = illegal_req;
          state_d = illegal_req ? ST_DONE : ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (!i_miso) begin
          cnt_d   = '0;
          state_d = ST_SHIFT_OUT;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      ST_SHIFT_OUT: begin
        // The packet shifts right so the current bit is always tx_q[0].
        tx_d = tx_q >> 1;
        if (cnt_q == (CntW'(len_q) - CntW'(1))) begin
          cnt_d   = '0;
          wait_d  = '0;
          state_d = ST_AWAIT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_AWAIT: begin
        if (i_miso) begin
          cnt_d   = '0;
          state_d = ST_SHIFT_IN;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      ST_SHIFT_IN: begin
        rx_shift_d = {i_miso, rx_shift_q[RxBits-1:1]};
        if (cnt_q == CntW'(RxBits - 1)) begin
          rx_data_d = rx_shift_d;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any handshake or final bit seen on the same edge.
    if (active && i_abort) begin
      rx_data_d = rx_data_q;
      err_d     = 1'b1;
      state_d   = ST_DONE;
    end
  end

  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_done  = (state_q == ST_DONE);
    o_error = (state_q == ST_DONE) && err_q;
    o_nss   = '1;
    o_mosi  = 1'b0;
    unique case (state_q)
      ST_REQUEST: begin
        o_nss  = nss_sel;
        o_mosi = 1'b1;
      end
      ST_SHIFT_OUT: begin
        o_nss  = nss_sel;
        o_mosi = tx_q[0];
      end
      ST_AWAIT:    o_nss = nss_sel;
      ST_SHIFT_IN: o_nss = nss_sel;
      default: begin
        o_nss  = '1;
        o_mosi = 1'b0;
      end
    endcase
  end

  assign o_rx_data   = rx_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Bench for spi_master_controller: directed table, async reset sequence, randomized transactions
// checked cycle by cycle against a timeline model of the protocol.
module tb_spi_master_controller;
  localparam int NS  = 3;
  localparam int MTX = 40;
  localparam int RXB = 16;
  localparam int TO  = 8;

  typedef struct {
    int          slave;
    int          len;
    logic [39:0] data;
    int          d1;        // extra cycles the slave holds miso high before ack
    int          d2;        // extra cycles the slave holds miso low before the response mark
    logic [15:0] resp;
    int          abort_at;  // edge index (after E0) at which i_abort is sampled, -1 for none
    int          exp_end;   // edge after which o_done is high
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start, i_abort, i_miso;
  logic [1:0]  i_slave;
  logic [5:0]  i_tx_len;
  logic [39:0] i_tx_data;
  logic        o_ready, o_done, o_error, o_mosi;
  logic [15:0] o_rx_data;
  logic [2:0]  o_nss;
  logic [2:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] rx_exp  = '0;
  vec_t        tbl[12];
  vec_t        v;

  spi_master_controller #(
    .NumSlaves(NS), .MaxTxBits(MTX), .RxBits(RXB), .TimeoutCycles(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(i_start), .i_slave(i_slave),
    .i_tx_len(i_tx_len), .i_tx_data(i_tx_data), .i_abort(i_abort),
    .o_ready(o_ready), .o_done(o_done), .o_error(o_error), .o_rx_data(o_rx_data),
    .o_nss(o_nss), .o_mosi(o_mosi), .i_miso(i_miso), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int slave, input int len, input logic [39:0] data,
                              input int d1, input int d2, input logic [15:0] resp,
                              input int abort_at, input int exp_end, input bit exp_err);
    vec_t r;
    r.slave = slave; r.len = len; r.data = data; r.d1 = d1; r.d2 = d2;
    r.resp = resp; r.abort_at = abort_at; r.exp_end = exp_end; r.exp_err = exp_err;
    return r;
  endfunction

  // Protocol timeline: request at E0, ack at E(1+d1), packet for len edges, response mark
  // after d2 idle edges, then RXB response edges; timeouts and abort cut the timeline short.
  function automatic vec_t with_ref(input vec_t r);
    vec_t o = r;
    if (r.slave >= NS || r.len == 0 || r.len > MTX) begin
      o.exp_end = 0;
      o.exp_err = 1'b1;
      return o;
    end
    if (r.d1 >= TO) begin
      o.exp_end = TO;
      o.exp_err = 1'b1;
    end else if (r.d2 >= TO) begin
      o.exp_end = r.d1 + r.len + 1 + TO;
      o.exp_err = 1'b1;
    end else begin
      o.exp_end = r.d1 + r.len + 2 + r.d2 + RXB;
      o.exp_err = 1'b0;
    end
    if (r.abort_at >= 1 && r.abort_at <= o.exp_end) begin
      o.exp_end = r.abort_at;
      o.exp_err = 1'b1;
    end
    return o;
  endfunction

  // Slave behaviour: miso level sampled at edge E(t).
  function automatic logic miso_at(input vec_t r, input int t);
    int tm;
    tm = r.d1 + r.len + 2 + r.d2;
    if (t <= r.d1)      return 1'b1;
    if (t == r.d1 + 1)  return 1'b0;
    if (t < tm)         return 1'b0;
    if (t == tm)        return 1'b1;
    if (t <= tm + RXB)  return r.resp[t - tm - 1];
    return 1'b1;
  endfunction

  function automatic logic mosi_exp(input vec_t r, input int t);
    if (t <= r.d1)         return 1'b1;
    if (t <= r.d1 + r.len) return r.data[t - r.d1 - 1];
    return 1'b0;
  endfunction

  // Called at a negedge; stop_t >= 0 returns right after checking that cycle.
  task automatic run_txn(input vec_t r, input int stop_t);
    logic [2:0] sel;
    sel = 3'b111;
    if (r.slave < NS) sel[r.slave] = 1'b0;
    i_start   = 1'b1;
    i_slave   = 2'(r.slave);
    i_tx_len  = 6'(r.len);
    i_tx_data = r.data;
    i_miso    = miso_at(r, 0);
    i_abort   = (r.abort_at == 0);
    for (int t = 0; t <= r.exp_end + 1; t++) begin
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      if (t < r.exp_end) begin
        chk("busy_ready", o_ready, 0);
        chk("busy_done", o_done, 0);
        chk("busy_error", o_error, 0);
        chk("busy_nss", o_nss, sel);
        chk("busy_mosi", o_mosi, mosi_exp(r, t));
      end else if (t == r.exp_end) begin
        chk("done_pulse", o_done, 1);
        chk("done_error", o_error, r.exp_err);
        chk("done_nss", o_nss, 3'b111);
        chk("done_mosi", o_mosi, 0);
        chk("done_ready", o_ready, 0);
      end else begin
        chk("idle_ready", o_ready, 1);
        chk("idle_done", o_done, 0);
        chk("idle_nss", o_nss, 3'b111);
        chk("rx_data", o_rx_data, r.exp_err ? rx_exp : r.resp);
      end
      i_miso  = miso_at(r, t + 1);
      i_abort = (r.abort_at == t + 1);
      if (t == stop_t) break;
    end
    if (stop_t < 0 && !r.exp_err) rx_exp = r.resp;
  endtask

  initial begin
    i_start = 1'b0; i_abort = 1'b0; i_miso = 1'b1;
    i_slave = '0; i_tx_len = '0; i_tx_data = '0;

    // directed vectors: slave, len, data, d1, d2, resp, abort_at, exp_end, exp_err
    tbl[0]  = mk(0, 40, 40'h12_3456_789A, 0, 0, 16'hBEEF, -1, 58, 0);
    tbl[1]  = mk(2, 32, 40'hFF_CAFE_F00D, 5, 3, 16'h1357, -1, 58, 0);
    tbl[2]  = mk(1, 8,  40'h00_0000_00A5, 100, 0, 16'hFFFF, -1, 8, 1);
    tbl[3]  = mk(3, 8,  40'h00_0000_00A5, 0, 0, 16'h5555, -1, 0, 1);
    tbl[4]  = mk(0, 0,  40'h00_0000_00A5, 0, 0, 16'h5555, -1, 0, 1);
    tbl[5]  = mk(1, 20, 40'h00_000F_0F0F, 0, 0, 16'h7777, 11, 11, 1);
    tbl[6]  = mk(0, 16, 40'h00_0000_C3A5, 0, 0, 16'h0F0F, -1, 34, 0);
    tbl[7]  = mk(0, 41, 40'hFF_FFFF_FFFF, 0, 0, 16'h1111, -1, 0, 1);
    tbl[8]  = mk(1, 1,  40'h00_0000_0001, 0, 0, 16'h8001, 0, 19, 0);
    tbl[9]  = mk(2, 4,  40'h00_0000_0009, 0, 20, 16'h2222, -1, 13, 1);
    tbl[10] = mk(2, 5,  40'h00_0000_0015, 0, 0, 16'h3333, 1, 1, 1);
    tbl[11] = mk(0, 3,  40'h00_0000_0005, 0, 0, 16'h4444, 10, 10, 1);

    // reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_nss", o_nss, 3'b111);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_rx", o_rx_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn(tbl[i], -1);

    // async reset in the middle of SHIFT_IN
    v = with_ref(mk(0, 8, 40'h00_0000_005A, 0, 0, 16'h1234, -1, 0, 0));
    run_txn(v, 13);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_nss", o_nss, 3'b111);
    chk("arst_rx", o_rx_data, 0);
    chk("arst_ready", o_ready, 1);
    chk("arst_done", o_done, 0);
    @(negedge clk);
    rst_n = 1'b1; i_miso = 1'b1; i_abort = 1'b0;
    rx_exp = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("arst_no_done", o_done, 0);
    end

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      v.slave = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      case ($urandom_range(0, 15))
        0:       v.len = 0;
        1:       v.len = 41;
        default: v.len = int'($urandom_range(1, 40));
      endcase
      v.data[31:0]  = $urandom;
      v.data[39:32] = 8'($urandom);
      v.d1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 6));
      v.d2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 6));
      v.resp = 16'($urandom);
      v.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1;
      run_txn(with_ref(v), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_controller.md
# spi_master_controller

Parametrised SPI master that runs one complete request/response transaction with an attached coprocessor slave (ALU, barrel shifter, multiplier, or any later block using the same serial handshake). The processor core hands it a slave index, a variable-length transmit packet and a start pulse. The block runs the mark/ack handshake, shifts the packet out, waits for the response mark, then shifts a fixed-width result in. It adds per-request length, timeout, abort and error reporting on top of the fixed inline SPI sequencing in the current core.

## Interface
- NumSlaves, 3: number of chip selects; must be ≥1.
- MaxTxBits, 40: transmit register width; upper bound on i_tx_len.
- RxBits, 16: response width in bits.
- TimeoutCycles, 255: maximum sampled edges spent in each wait state; must be ≥1.

- i_clock  in  1  system clock. The SPI sclk is this clock and is driven by the parent, not by this block.
- i_reset  in  1  reset, asynchronous, active-low.
- i_start  in  1  request strobe; accepted only when o_ready=1.
- i_slave  in  $clog2(NumSlaves) (min 1)  target slave index.
- i_tx_len  in  $clog2(MaxTxBits+1)  number of bits to send, legal range 1..MaxTxBits.
- i_tx_data  in  MaxTxBits  packet, sent LSB first.
- i_abort  in  1  synchronous abort of the transaction in progress.
- o_ready  out  1  high in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  one-cycle pulse, coincident with o_done on failure.
- o_rx_data  out  RxBits  last successful response; held between transactions.
- o_nss  out  NumSlaves  active-low chip selects.
- o_mosi  out  1  master out.
- i_miso  in  1  slave out, sampled on posedge i_clock.

## Operation
States and transitions:
- **IDLE**
  - o_ready=1, o_nss all ones, o_mosi=0.
  - On i_start: latch i_slave, i_tx_len and i_tx_data.
  - Illegal request (i_slave≥NumSlaves, i_tx_len=0, or i_tx_len>MaxTxBits) → DONE with error; no nss is ever asserted.
  - Legal request → REQUEST.
- **REQUEST**
  - o_nss[slave]=0, o_mosi=1.
  - i_miso=0 sampled → SHIFT_OUT.
- **SHIFT_OUT**
  - o_mosi=tx[bit_cnt]; bit_cnt increments on each edge.
  - After tx_len bits → AWAIT; bit_cnt clears.
- **AWAIT**
  - o_mosi=0, nss still asserted.
  - i_miso=1 sampled → SHIFT_IN.
- **SHIFT_IN**
  - rx_shift[bit_cnt]←i_miso on each edge, LSB first.
  - After RxBits edges: o_rx_data←full response → DONE.
- **DONE**
  - o_done=1 for one cycle; o_nss all ones, o_mosi=0.
  - o_error=1 if entered via timeout, abort or illegal request.
  - → IDLE.

Rules:
- Timeout: a wait counter clears on entry to REQUEST or AWAIT. If TimeoutCycles edges pass in one of these states with no handshake seen → DONE with error.
- Abort: i_abort in any state except IDLE or DONE → DONE with error on the next edge. Abort has priority over a handshake or last bit seen on the same edge. i_abort in IDLE is ignored, even together with i_start.
- o_rx_data is updated only on successful completion; error paths leave it unchanged.
- i_start while o_ready=0 is ignored; it is not queued.
- Exactly one nss bit is low, and only in REQUEST, SHIFT_OUT, AWAIT and SHIFT_IN.

## Timing
- Reset (async, any state):
  - State→IDLE.
  - o_nss='1, o_mosi=0, o_done=0, o_error=0, o_rx_data=0, o_ready=1.
  - Counters and latched request cleared.
  - A reset mid-transaction deasserts nss immediately, without waiting for a clock edge.
- Accepting edge is E0. With slave responses immediate (i_miso=0 sampled at E1, i_miso=1 at E0+tx_len+2):
  - Bit k of the packet is on o_mosi between E1+k and E2+k.
  - Response bit k is sampled at E0+tx_len+3+k.
  - o_done is high in the cycle after E0+tx_len+RxBits+2.
  - o_ready is high again one cycle later.
- Illegal request: o_done/o_error high in the cycle right after E0.
- Timeout in REQUEST: o_done/o_error high in the cycle after E0+TimeoutCycles.
- Back-to-back: i_start may be asserted in the first o_ready cycle after o_done.

## Test plan
- Slave 0, tx_len=40, tx=0x00_1234_5678_9A, slave acks immediately and returns 0xBEEF → 40 mosi bits match LSB first, o_rx_data=0xBEEF, o_done at E0+58, o_error=0, nss[0] is the only select low.
- Slave 2, tx_len=32, slave delays the ack by 5 cycles and the response mark by 3 cycles → correct data, o_done delayed by exactly 8 cycles, no error.
- TimeoutCycles=8, slave 1 never pulls miso low → o_done+o_error at E0+8, nss released, o_rx_data keeps its previous value.
- i_slave=3 (NumSlaves=3), and separately tx_len=0 → o_done+o_error in the cycle after E0, o_nss stays all ones throughout.
- i_abort pulsed on the 10th SHIFT_OUT bit → DONE with error next cycle; a new transaction started immediately afterwards completes correctly.
- i_reset pulsed low asynchronously mid-SHIFT_IN → o_nss='1, o_rx_data=0, o_ready=1 before the next clock edge; no o_done pulse.
